// File: rtl/systolic_skew_control.sv
// Operand-skew and load sequencer for an N x M output-stationary systolic MAC array.
// Define SKEW_CTRL_REPEAT_EN to run passes back-to-back instead of stopping in DONE after one load.
module systolic_skew_control #(
    parameter int N = 3,
    parameter int M = 3,
    parameter int K = 3
) (
    input  logic         clk,
    input  logic         rst,
    output logic [N-1:0] A_start_en,
    output logic [M-1:0] B_start_en,
    output logic         load
);

    localparam int CW    = $clog2(N + M + K) + 1;
    localparam int MAXNM = (N > M) ? N : M;
    localparam logic [CW-1:0] FEED_LAST = CW'(K + MAXNM - 2);
    localparam logic [CW-1:0] LOAD_T    = CW'(N + M + K - 2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FEED  = 3'd1,
        DRAIN = 3'd2,
        LOAD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_t;
    logic [CW-1:0] w_t_inc;
    logic          w_feed;
    logic [N-1:0]  w_a_en;
    logic [M-1:0]  w_b_en;

    assign w_t_inc = r_t + CW'(1);
    assign w_feed  = (r_state == FEED);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_t     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= FEED;
                    r_t     <= '0;
                end
                FEED: begin
                    r_t <= w_t_inc;
                    // DRAIN can be empty (e.g. N = M = K = 1), so FEED may jump straight to LOAD
                    if (w_t_inc == LOAD_T)
                        r_state <= LOAD;
                    else if (r_t == FEED_LAST)
                        r_state <= DRAIN;
                end
                DRAIN: begin
                    r_t <= w_t_inc;
                    if (w_t_inc == LOAD_T)
                        r_state <= LOAD;
                end
                LOAD: begin
                    r_t <= '0;
`ifdef SKEW_CTRL_REPEAT_EN
                    r_state <= FEED;
`else
                    r_state <= DONE;
`endif
                end
                DONE: begin
                    r_state <= DONE;
                end
                default: begin
                    r_state <= IDLE;
                    r_t     <= '0;
                end
            endcase
        end
    end

    // Lane g is active for t in [g, g+K-1]; the widened subtraction wraps to a large value when t < g.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_row
            logic [CW:0] w_da;
            assign w_da       = {1'b0, r_t} - (CW+1)'(gi);
            assign w_a_en[gi] = w_feed && (w_da < (CW+1)'(K));
        end
        for (genvar gi = 0; gi < M; gi++) begin : g_col
            logic [CW:0] w_db;
            assign w_db       = {1'b0, r_t} - (CW+1)'(gi);
            assign w_b_en[gi] = w_feed && (w_db < (CW+1)'(K));
        end
    endgenerate

    assign A_start_en = w_a_en;
    assign B_start_en = w_b_en;
    assign load       = (r_state == LOAD);

endmodule

// File: tb/tb_systolic_skew_control.sv
// Directed bench for systolic_skew_control in three geometries (3x3x3, 2x4x2, 1x1x1).
// Follows SKEW_CTRL_REPEAT_EN so the same bench checks either build.
module tb_systolic_skew_control;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [2:0] a333, b333;
    logic       l333;
    logic [1:0] a242;
    logic [3:0] b242;
    logic       l242;
    logic [0:0] a111, b111;
    logic       l111;

    logic [2:0] tab333   [8] = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000, 3'b000, 3'b000};
    logic [1:0] tab_a242 [7] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [3:0] tab_b242 [7] = '{4'b0001, 4'b0011, 4'b0110, 4'b1100, 4'b1000, 4'b0000, 4'b0000};

    always #5 clk = ~clk;

    systolic_skew_control #(.N(3), .M(3), .K(3)) u333 (
        .clk(clk), .rst(rst), .A_start_en(a333), .B_start_en(b333), .load(l333));
    systolic_skew_control #(.N(2), .M(4), .K(2)) u242 (
        .clk(clk), .rst(rst), .A_start_en(a242), .B_start_en(b242), .load(l242));
    systolic_skew_control #(.N(1), .M(1), .K(1)) u111 (
        .clk(clk), .rst(rst), .A_start_en(a111), .B_start_en(b111), .load(l111));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves every DUT sampled in its first FEED cycle (t = 0).
    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            $display("reset cycle %0d: a333=%b b333=%b l333=%b", c, a333, b333, l333);
            checks++;
            if ({a333, b333, l333, a242, b242, l242, a111, b111, l111} !== 20'd0) begin
                errors++;
                $display("FAIL reset_zero cycle %0d: got %b want 0", c,
                         {a333, b333, l333, a242, b242, l242, a111, b111, l111});
            end
        end
        rst = 1'b0;
        $display("idle cycle: a333=%b b333=%b l333=%b", a333, b333, l333);
        checks++;
        if ({a333, b333, l333, a242, b242, l242, a111, b111, l111} !== 20'd0) begin
            errors++;
            $display("FAIL idle_zero: got %b want 0",
                     {a333, b333, l333, a242, b242, l242, a111, b111, l111});
        end
        tick();
        checks++;
        if (a333 !== 3'b001) begin
            errors++;
            $display("FAIL first_feed a333: got %b want 001", a333);
        end
    endtask

    task automatic test_skew_333();
        do_reset();
        for (int t = 0; t < 8; t++) begin
            $display("333 t=%0d a=%b b=%b load=%b", t, a333, b333, l333);
            checks += 3;
            if (a333 !== tab333[t]) begin
                errors++;
                $display("FAIL skew333_a t=%0d: got %b want %b", t, a333, tab333[t]);
            end
            if (b333 !== tab333[t]) begin
                errors++;
                $display("FAIL skew333_b t=%0d: got %b want %b", t, b333, tab333[t]);
            end
            if (l333 !== (t == 7)) begin
                errors++;
                $display("FAIL skew333_load t=%0d: got %b want %b", t, l333, (t == 7));
            end
            tick();
        end
    endtask

    task automatic test_asym_242();
        do_reset();
        for (int t = 0; t < 7; t++) begin
            $display("242 t=%0d a=%b b=%b load=%b", t, a242, b242, l242);
            checks += 3;
            if (a242 !== tab_a242[t]) begin
                errors++;
                $display("FAIL asym_a t=%0d: got %b want %b", t, a242, tab_a242[t]);
            end
            if (b242 !== tab_b242[t]) begin
                errors++;
                $display("FAIL asym_b t=%0d: got %b want %b", t, b242, tab_b242[t]);
            end
            if (l242 !== (t == 6)) begin
                errors++;
                $display("FAIL asym_load t=%0d: got %b want %b", t, l242, (t == 6));
            end
            tick();
        end
    endtask

    task automatic test_degenerate_111();
        do_reset();
        for (int t = 0; t < 2; t++) begin
            $display("111 t=%0d a=%b b=%b load=%b", t, a111, b111, l111);
            checks += 3;
            if (a111 !== 1'(t == 0)) begin
                errors++;
                $display("FAIL degen_a t=%0d: got %b want %b", t, a111, (t == 0));
            end
            if (b111 !== 1'(t == 0)) begin
                errors++;
                $display("FAIL degen_b t=%0d: got %b want %b", t, b111, (t == 0));
            end
            if (l111 !== (t == 1)) begin
                errors++;
                $display("FAIL degen_load t=%0d: got %b want %b", t, l111, (t == 1));
            end
            tick();
        end
    endtask

    task automatic test_after_load();
        logic [2:0] exp_en;
        logic       exp_l;
        do_reset();
        for (int c = 0; c < 58; c++) begin
`ifdef SKEW_CTRL_REPEAT_EN
            exp_en = tab333[c % 8];
            exp_l  = ((c % 8) == 7);
`else
            exp_en = (c < 8) ? tab333[c] : 3'b000;
            exp_l  = (c == 7);
`endif
            $display("run c=%0d a=%b b=%b load=%b", c, a333, b333, l333);
            checks += 3;
            if (a333 !== exp_en) begin
                errors++;
                $display("FAIL after_load_a c=%0d: got %b want %b", c, a333, exp_en);
            end
            if (b333 !== exp_en) begin
                errors++;
                $display("FAIL after_load_b c=%0d: got %b want %b", c, b333, exp_en);
            end
            if (l333 !== exp_l) begin
                errors++;
                $display("FAIL after_load_load c=%0d: got %b want %b", c, l333, exp_l);
            end
            tick();
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        tick();
        tick();
        checks++;
        if (a333 !== 3'b111) begin
            errors++;
            $display("FAIL midrst_pre a333: got %b want 111", a333);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        $display("midrst after rst: a=%b b=%b load=%b", a333, b333, l333);
        checks++;
        if ({a333, b333, l333} !== 7'd0) begin
            errors++;
            $display("FAIL midrst_zero: got %b want 0", {a333, b333, l333});
        end
        tick();
        for (int t = 0; t < 8; t++) begin
            $display("midrst t=%0d a=%b load=%b", t, a333, l333);
            checks += 2;
            if (a333 !== tab333[t]) begin
                errors++;
                $display("FAIL midrst_a t=%0d: got %b want %b", t, a333, tab333[t]);
            end
            if (l333 !== (t == 7)) begin
                errors++;
                $display("FAIL midrst_load t=%0d: got %b want %b", t, l333, (t == 7));
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_skew_333();
        test_asym_242();
        test_degenerate_111();
        test_after_load();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
